filter_sweep_ctrl: RTL
======================

Name: filter_sweep_ctrl

Overview:
- Sequencer for the exponential test-signal generator and the eight filter channels.
- Drives the generator's overlay, rate and delay controls through a programmed delay sweep.
- For each delay step it fires one test pulse, then captures the peak of one selected filter output over a fixed window.
- Streams one result per delay step to the readout logic through a valid/ready handshake.

Parameters:
SIZE_DELAY, 8, width of delay values (matches package_settings)
SIZE_FILTER_DATA, 16, width of each filter output (two's complement)
SETTLE_CYCLES, 4, cycles delay is held stable before firing, >=1
WINDOW_CYCLES, 64, measurement window length in cycles, >=2

Ports:
clk  in  1  system clock
reset  in  1  synchronous reset, active-low
start  in  1  one-cycle pulse; launches a sweep when idle
abort  in  1  level; terminates the sweep
cfg_delay_min  in  SIZE_DELAY  first delay value
cfg_delay_max  in  SIZE_DELAY  last delay value (inclusive)
cfg_delay_step  in  SIZE_DELAY  delay increment; 0 is treated as 1
cfg_overlay  in  1  overlay value driven during the sweep
cfg_chan_sel  in  3  filter channel measured (0 = v1 … 7 = v8)
filt_data  in  8*SIZE_FILTER_DATA  packed filter outputs; channel k occupies bits [k*W +: W]
test_overlay  out  1  to generator overlay
test_rate  out  1  to generator rate (trigger)
test_delay  out  SIZE_DELAY  to generator delay
res_valid  out  1  result available
res_ready  in  1  downstream accepts result
res_delay  out  SIZE_DELAY  delay of the reported step
res_peak  out  SIZE_FILTER_DATA  signed maximum seen in the window
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at sweep end or abort

Behaviour:
- All registers update on the rising edge of clk.
- reset==0 at an edge forces the FSM to IDLE and clears all outputs (test_delay=0, test_rate=0, test_overlay=0, res_*=0, busy=0, done=0), regardless of current state.
- Config sampling: cfg_* are sampled into internal registers in the cycle start is accepted. Changes during the sweep are ignored.
- A step of 0 is latched as 1.
- If min>max, the sweep executes exactly one step at min.
- States:
  - IDLE: start=1 -> ARM; cur_delay=min; test_delay=min; test_overlay=cfg_overlay. start is ignored in any other state.
  - ARM: hold test_delay for SETTLE_CYCLES cycles -> FIRE.
  - FIRE: test_rate=1 for exactly one cycle; peak register is loaded with the most negative value (0x8000 for W=16); -> MEASURE.
  - MEASURE: for WINDOW_CYCLES cycles, compare the selected channel (signed) and update the peak when the sample is strictly greater.
    - The first compared sample is the one present in the first MEASURE cycle.
    - -> REPORT.
  - REPORT: res_valid=1; res_delay=cur_delay; res_peak=peak. Outputs are held stable until res_valid&res_ready. On the handshake cycle:
    - if cur_delay+step > max, or the addition overflows SIZE_DELAY bits: -> DONE;
    - else cur_delay+=step, test_delay is updated, -> ARM.
    - res_valid drops in the cycle after the handshake.
  - DONE: done=1 for one cycle; test_overlay=0; test_delay keeps its last value -> IDLE.
- test_rate is 0 in all states except FIRE.
- abort=1 in ARM, FIRE, MEASURE or REPORT -> DONE next cycle.
  - The pending result is discarded; res_valid deasserts.
  - abort has priority over a simultaneous handshake. If both are asserted in REPORT, the result is NOT considered delivered.
- Latency:
  - start to first test_rate: 1+SETTLE_CYCLES cycles.
  - FIRE to res_valid: WINDOW_CYCLES+1 cycles.
- Steps per sweep: floor((max-min)/step)+1.
- Peak compare is full-width signed; no saturation or truncation.
- Reset mid-sweep: immediate return to IDLE, with no done pulse.

Test Plan:
1. min=10, max=30, step=10, chan=2, channel 2 driven with a ramp 0..63 per window, res_ready=1 -> three results: (10,63), (20,63), (30,63); three test_rate pulses; done once; busy low after.
2. Same sweep with res_ready held 0 for 20 cycles at the first report -> res_valid, res_delay=10 and res_peak stay stable for 20 cycles; no second test_rate until the handshake.
3. Channel 5 constant -100 (0xFF9C), single step min=max=7 -> exactly one result with res_peak=0xFF9C; channels 0-4 and 6-7 at +500 do not affect the result.
4. step=0, min=250, max=255 -> six results, delays 250..255; min=200, max=255, step=100 -> results at 200 only (overflow check).
5. abort asserted during MEASURE of step 2 -> no second result; done pulses; test_rate stays 0; a new start launches a fresh sweep from min.
6. reset low during REPORT with res_valid=1 -> next cycle all outputs 0, FSM in IDLE, no done pulse; start asserted together with reset low is ignored.

Source files
------------

// File: rtl/filter_sweep_ctrl.sv
// filter_sweep_ctrl: steps the test-signal generator delay through a programmed
// range, fires one pulse per step, captures the signed peak of one filter
// channel over a fixed window and streams (delay, peak) to the readout.
module filter_sweep_ctrl #(
  parameter int SIZE_DELAY       = 8,
  parameter int SIZE_FILTER_DATA = 16,
  parameter int SETTLE_CYCLES    = 4,
  parameter int WINDOW_CYCLES    = 64
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               abort,
  input  logic [SIZE_DELAY-1:0]              cfg_delay_min,
  input  logic [SIZE_DELAY-1:0]              cfg_delay_max,
  input  logic [SIZE_DELAY-1:0]              cfg_delay_step,
  input  logic                               cfg_overlay,
  input  logic [2:0]                         cfg_chan_sel,
  input  logic [8*SIZE_FILTER_DATA-1:0]      filt_data,
  output logic                               test_overlay,
  output logic                               test_rate,
  output logic [SIZE_DELAY-1:0]              test_delay,
  output logic                               res_valid,
  input  logic                               res_ready,
  output logic [SIZE_DELAY-1:0]              res_delay,
  output logic signed [SIZE_FILTER_DATA-1:0] res_peak,
  output logic                               busy,
  output logic                               done
);

  localparam int CNT_MAX = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WINDOW_LAST = CNT_W'(WINDOW_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_FIRE,
    S_MEASURE,
    S_REPORT,
    S_DONE
  } state_t;

  state_t                               state_q, state_d;
  logic [CNT_W-1:0]                     cnt_q, cnt_d;
  logic [SIZE_DELAY-1:0]                cur_q, cur_d;
  logic [SIZE_DELAY-1:0]                max_q, max_d;
  logic [SIZE_DELAY-1:0]                step_q, step_d;
  logic [2:0]                           chan_q, chan_d;
  logic                                 ovl_q, ovl_d;
  logic [SIZE_DELAY-1:0]                delay_q, delay_d;
  logic signed [SIZE_FILTER_DATA-1:0]   peak_q, peak_d;
  logic [SIZE_DELAY-1:0]                rdelay_q, rdelay_d;
  logic signed [SIZE_FILTER_DATA-1:0]   rpeak_q, rpeak_d;

  logic signed [SIZE_FILTER_DATA-1:0]   chan_arr [8];
  logic signed [SIZE_FILTER_DATA-1:0]   sample;
  logic signed [SIZE_FILTER_DATA-1:0]   peak_upd;
  logic [SIZE_DELAY:0]                  next_sum;
  logic                                 last_step;

  // Running signed maximum; only a strictly greater sample replaces the peak.
  function automatic logic signed [SIZE_FILTER_DATA-1:0] peak_max(
    input logic signed [SIZE_FILTER_DATA-1:0] cur,
    input logic signed [SIZE_FILTER_DATA-1:0] smp
  );
    return (smp > cur) ? smp : cur;
  endfunction

  // The sweep ends when the next delay passes max or cannot be represented.
  function automatic logic sweep_last(
    input logic [SIZE_DELAY:0]   sum,
    input logic [SIZE_DELAY-1:0] dmax
  );
    return sum[SIZE_DELAY] || (sum[SIZE_DELAY-1:0] > dmax);
  endfunction

  // Unpack the eight filter channels so the selection is a plain array index.
  for (genvar k = 0; k < 8; k++) begin : g_unpack
    assign chan_arr[k] = filt_data[k*SIZE_FILTER_DATA +: SIZE_FILTER_DATA];
  end

  assign sample    = chan_arr[chan_q];
  assign peak_upd  = peak_max(peak_q, sample);
  assign next_sum  = {1'b0, cur_q} + {1'b0, step_q};
  assign last_step = sweep_last(next_sum, max_q);

  // Next-state and datapath update for the sweep sequencer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cur_d    = cur_q;
    max_d    = max_q;
    step_d   = step_q;
    chan_d   = chan_q;
    ovl_d    = ovl_q;
    delay_d  = delay_q;
    peak_d   = peak_q;
    rdelay_d = rdelay_q;
    rpeak_d  = rpeak_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ARM;
          cnt_d   = '0;
          cur_d   = cfg_delay_min;
          max_d   = cfg_delay_max;
          step_d  = (cfg_delay_step == '0) ? SIZE_DELAY'(1) : cfg_delay_step;
          chan_d  = cfg_chan_sel;
          ovl_d   = cfg_overlay;
          delay_d = cfg_delay_min;
        end
      end
      S_ARM: begin
        if (abort) begin
          state_d = S_DONE;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = S_FIRE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FIRE: begin
        if (abort) begin
          state_d = S_DONE;
        end else begin
          state_d = S_MEASURE;
          cnt_d   = '0;
          peak_d  = {1'b1, {(SIZE_FILTER_DATA-1){1'b0}}};
        end
      end
      S_MEASURE: begin
        if (abort) begin
          state_d = S_DONE;
        end else begin
          peak_d = peak_upd;
          if (cnt_q == WINDOW_LAST) begin
            state_d  = S_REPORT;
            rdelay_d = cur_q;
            rpeak_d  = peak_upd;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_REPORT: begin
        if (abort) begin
          state_d = S_DONE;
        end else if (res_ready) begin
          if (last_step) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ARM;
            cnt_d   = '0;
            cur_d   = next_sum[SIZE_DELAY-1:0];
            delay_d = next_sum[SIZE_DELAY-1:0];
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Overlay is released for the done cycle and stays off while idle.
    if (state_d == S_DONE) begin
      ovl_d = 1'b0;
    end
  end

  // State and datapath registers; reset returns everything to idle with outputs cleared.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      cur_q    <= '0;
      max_q    <= '0;
      step_q   <= '0;
      chan_q   <= '0;
      ovl_q    <= 1'b0;
      delay_q  <= '0;
      peak_q   <= '0;
      rdelay_q <= '0;
      rpeak_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cur_q    <= cur_d;
      max_q    <= max_d;
      step_q   <= step_d;
      chan_q   <= chan_d;
      ovl_q    <= ovl_d;
      delay_q  <= delay_d;
      peak_q   <= peak_d;
      rdelay_q <= rdelay_d;
      rpeak_q  <= rpeak_d;
    end
  end

  assign test_overlay = ovl_q;
  assign test_delay   = delay_q;
  assign test_rate    = (state_q == S_FIRE);
  assign res_valid    = (state_q == S_REPORT);
  assign res_delay    = rdelay_q;
  assign res_peak     = rpeak_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);

endmodule
